spi_frame_tx: RTL and testbench
===============================

SPI_FRAME_TX -- requirements
Module: spi_frame_tx

Interface
REQ-001 Parameter CLK_DIV, 2, clk cycles per spi_clk half-period (legal 1..255).
REQ-002 Parameter WORDS, 2048, 32-bit words per frame (legal 1..2048).
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle frame request; sampled only in IDLE.
REQ-006 abort  input  1  terminates the frame in progress.
REQ-007 busy  output  1  high from the cycle after an accepted start until the return to IDLE.
REQ-008 done  output  1  one-cycle pulse when a frame completes normally.
REQ-009 rd_en  output  1  frame-buffer read strobe.
REQ-010 rd_addr  output  11  frame-buffer word address.
REQ-011 rd_data  input  32  read data, valid exactly 1 clk after rd_en (synchronous RAM).
REQ-012 spi_clk  output  1  SPI clock, idle low.
REQ-013 spi_mosi  output  1  SPI data, MSB first.
REQ-014 spi_cs  output  1  active-low chip select, idle high.

Function
REQ-015 The block is the SPI host that streams one frame of WORDS words to the panel's SPI satellite; SPI mode 0 (satellite samples on rising spi_clk; mosi changes only while spi_clk is low).
REQ-016 States: IDLE, LEAD, SHIFT, TRAIL; all outputs are registered.
REQ-017 IDLE -> LEAD on start: spi_cs=0, rd_en=1, rd_addr=0, word counter=0, and busy=1 in the next cycle.
REQ-018 LEAD lasts CLK_DIV cycles, spi_clk=0; rd_data is loaded into the 32-bit shift register and spi_mosi=bit31 before LEAD ends.
REQ-019 SHIFT, per bit: spi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles; the shift advances and mosi updates on the high->low transition.
REQ-020 Each bit takes 2*CLK_DIV cycles; each word takes 64*CLK_DIV cycles; there are no gaps between words, and cs stays low for the whole frame.
REQ-021 Prefetch: at the start of bit 16 (counting from 31 down) of word n < WORDS-1, pulse rd_en for 1 cycle with rd_addr=n+1; capture rd_data into the holding register 1 cycle later.
REQ-022 After the high half of bit 0 of word n < WORDS-1: load the holding register into the shift register, increment the word counter, and drive mosi=bit31 of the new word.
REQ-023 After bit 0 of word WORDS-1: enter TRAIL with spi_clk=0 for CLK_DIV cycles, then spi_cs=1, done=1 for 1 cycle, busy=0, and return to IDLE.
REQ-024 rd_addr holds its last value while rd_en=0; rd_en is never asserted in IDLE or TRAIL.
REQ-025 Total spi_cs low time = CLK_DIV*(2+64*WORDS) cycles.
REQ-026 start asserted while busy=1 is ignored, and is not queued.
REQ-027 start in the same cycle as done is ignored; start in the cycle after done is accepted.
REQ-028 abort in any non-IDLE state: in the next cycle spi_cs=1, spi_clk=0, spi_mosi=0, busy=0, and the block is in IDLE; done is not pulsed, and a pending prefetch is discarded.
REQ-029 abort and start together in IDLE: abort wins and no frame starts.
REQ-030 The half-period counter and bit counter are sized for CLK_DIV=255 and WORDS=2048 with no wrap inside a frame; the word counter is 11 bits.

Reset
REQ-031 While resetn=0, asynchronously: state=IDLE, spi_cs=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rd_en=0, rd_addr=0, and the shift register, holding register and counters are 0.
REQ-032 Reset asserted mid-frame truncates the SPI transfer immediately (cs high), with no done pulse.
REQ-033 After reset release, the first start is accepted on the first clk edge.

Verification
REQ-034 Reset: assert resetn=0 mid-SHIFT -> same-cycle cs=1, spi_clk=0, busy=0, and no done.
REQ-035 Frame (CLK_DIV=2, WORDS=4, RAM = 0x80000001, 0x12345678, 0xFFFF0000, 0x00000000) -> satellite model captures the same 4 words in order; cs low exactly 516 cycles; 128 rising spi_clk edges; one done pulse.
REQ-036 Timing (CLK_DIV=1, WORDS=2) -> spi_clk toggles every cycle; no inter-word gap; rd_en pulses once, with rd_addr=1 during bit 16 of word 0; cs low 130 cycles.
REQ-037 start pulsed while busy, and in the same cycle as done -> both ignored; start 1 cycle after done -> second frame starts, and cs rises for exactly 1 cycle between frames.
REQ-038 abort asserted during bit 5 of word 2 -> next cycle cs=1, busy=0; no done; a following start transmits from word 0.
REQ-039 Checker on every run: mosi is stable while spi_clk is high, and spi_clk is low whenever cs is high.

Source files
------------

// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI host (mode 0) that streams one frame of WORDS 32-bit
// words from a synchronous frame buffer to the panel's SPI satellite.
//
// Ports:
//   clk, resetn        system clock, asynchronous active-low reset
//   start, abort       frame request (sampled in IDLE) / frame kill
//   busy, done         frame active / one-cycle completion pulse
//   rd_en, rd_addr     frame-buffer read strobe and word address
//   rd_data            read data, valid 1 clk after rd_en
//   spi_clk, spi_mosi  SPI clock (idle low) and data (MSB first)
//   spi_cs             active-low chip select (idle high)
//
// Frame timing: LEAD (CLK_DIV cycles, first word fetched), SHIFT
// (64*CLK_DIV cycles per word, back to back), TRAIL (CLK_DIV cycles).
// done pulses in the last TRAIL cycle and cs rises on the following edge,
// so a start in the cycle after done gives a 1-cycle cs-high gap.
module spi_frame_tx #(
    parameter int CLK_DIV = 2,
    parameter int WORDS   = 2048
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [10:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        spi_clk,
    output logic        spi_mosi,
    output logic        spi_cs
);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    localparam logic [7:0]  HMAX  = 8'(CLK_DIV - 1);
    localparam logic [10:0] WLAST = 11'(WORDS - 1);

    state_t      state_q, state_d;
    logic [7:0]  hcnt_q, hcnt_d;     // cycles within the current half-period
    logic [4:0]  bit_q, bit_d;       // bit on the wire, 31 down to 0
    logic [10:0] word_q, word_d;
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] hold_q, hold_d;     // prefetched next word
    logic        first_q, first_d;   // next returned read is word 0 -> shreg
    logic        rd_vld_q, rd_vld_d; // rd_data carries the last read this cycle
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_en_q, rd_en_d;
    logic [10:0] rd_addr_q, rd_addr_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_q, cs_d;
    logic        hcnt_end;

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign spi_clk  = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs   = cs_q;

    assign hcnt_end = (hcnt_q == HMAX);

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        bit_d     = bit_q;
        word_d    = word_q;
        shreg_d   = shreg_q;
        hold_d    = hold_q;
        first_d   = first_q;
        rd_vld_d  = rd_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = LEAD;
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = 11'd0;
                    word_d    = 11'd0;
                    hcnt_d    = 8'd0;
                    bit_d     = 5'd31;
                    first_d   = 1'b1;
                end
            end
            LEAD: begin
                hcnt_d = hcnt_q + 8'd1;
                if (hcnt_end) begin
                    hcnt_d  = 8'd0;
                    state_d = SHIFT;
                    bit_d   = 5'd31;
                end
            end
            SHIFT: begin
                hcnt_d = hcnt_q + 8'd1;
                if (hcnt_end) begin
                    hcnt_d = 8'd0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // high->low: the only point where mosi may change
                        sclk_d = 1'b0;
                        if (bit_q == 5'd0) begin
                            if (word_q == WLAST) begin
                                state_d = TRAIL;
                            end else begin
                                shreg_d = hold_q;
                                mosi_d  = hold_q[31];
                                word_d  = word_q + 11'd1;
                                bit_d   = 5'd31;
                            end
                        end else begin
                            bit_d   = bit_q - 5'd1;
                            shreg_d = {shreg_q[30:0], 1'b0};
                            mosi_d  = shreg_q[30];
                            // entering bit 16: fetch the next word
                            if (bit_q == 5'd17 && word_q != WLAST) begin
                                rd_en_d   = 1'b1;
                                rd_addr_d = word_q + 11'd1;
                            end
                        end
                    end
                end
            end
            TRAIL: begin
                hcnt_d = hcnt_q + 8'd1;
                if (hcnt_end) begin
                    hcnt_d  = 8'd0;
                    state_d = IDLE;
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    mosi_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read return. Word 0 goes straight to the shifter (inside LEAD for
        // CLK_DIV>=2; with CLK_DIV=1 it lands as bit 31's high half begins);
        // later words park in the holding register until the word boundary.
        if (rd_vld_q && state_q != IDLE) begin
            if (first_q) begin
                shreg_d = rd_data;
                mosi_d  = rd_data[31];
                first_d = 1'b0;
            end else begin
                hold_d = rd_data;
            end
        end

        done_d = (state_d == TRAIL) && (hcnt_d == HMAX);

        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            cs_d      = 1'b1;
            sclk_d    = 1'b0;
            mosi_d    = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            rd_en_d   = 1'b0;
            rd_addr_d = rd_addr_q;
            rd_vld_d  = 1'b0;
            first_d   = 1'b0;
            hcnt_d    = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            hcnt_q    <= 8'd0;
            bit_q     <= 5'd0;
            word_q    <= 11'd0;
            shreg_q   <= 32'd0;
            hold_q    <= 32'd0;
            first_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= 11'd0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            bit_q     <= bit_d;
            word_q    <= word_d;
            shreg_q   <= shreg_d;
            hold_q    <= hold_d;
            first_q   <= first_d;
            rd_vld_q  <= rd_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_q      <= cs_d;
        end
    end

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx. Two instances: index 0 (CLK_DIV=2, WORDS=4) and
// index 1 (CLK_DIV=1, WORDS=2). A negedge satellite monitor captures words
// on rising spi_clk and keeps running statistics; tests compare deltas of
// those statistics against values derived from the frame rules.
module tb_spi_frame_tx;
    localparam int CD0 = 2, W0 = 4, CD1 = 1, W1 = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  start = '0, abort = '0;
    logic [1:0]  busy, done, rd_en, spi_clk, spi_mosi, spi_cs;
    logic [10:0] rd_addr [2];
    logic [31:0] rd_data [2];
    logic [31:0] mem [2][4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_frame_tx #(.CLK_DIV(CD0), .WORDS(W0)) u_dut0 (
        .clk(clk), .resetn(resetn), .start(start[0]), .abort(abort[0]),
        .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .rd_data(rd_data[0]), .spi_clk(spi_clk[0]), .spi_mosi(spi_mosi[0]),
        .spi_cs(spi_cs[0]));

    spi_frame_tx #(.CLK_DIV(CD1), .WORDS(W1)) u_dut1 (
        .clk(clk), .resetn(resetn), .start(start[1]), .abort(abort[1]),
        .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .rd_data(rd_data[1]), .spi_clk(spi_clk[1]), .spi_mosi(spi_mosi[1]),
        .spi_cs(spi_cs[1]));

    // synchronous frame buffers
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (rd_en[i]) rd_data[i] <= mem[i][rd_addr[i][1:0]];
    end

    function automatic int cd(int i);
        return (i == 0) ? CD0 : CD1;
    endfunction

    // ---------------- satellite monitor ----------------
    int          cyc = 0;
    logic [1:0]  prev_clk = '0, prev_mosi = '0, prev_rden = '0;
    int          cs_low [2], rises [2], hi_cyc [2], done_n [2], rden_n [2];
    int          pf_n [2], rden_pos [2], cap_n [2], frise [2], bitn [2];
    int          last_rise [2], spacing_err [2], mosi_err [2], csclk_err [2];
    int          hi_run [2], last_gap [2], rden_long [2];
    logic [10:0] rden_addr [2];
    logic [31:0] cur [2];
    logic [31:0] cap [2][256];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            prev_clk[i]  <= spi_clk[i];
            prev_mosi[i] <= spi_mosi[i];
            prev_rden[i] <= rd_en[i];
            if (spi_cs[i] && spi_clk[i]) csclk_err[i] <= csclk_err[i] + 1;
            if (prev_clk[i] && spi_clk[i] && (spi_mosi[i] !== prev_mosi[i]))
                mosi_err[i] <= mosi_err[i] + 1;
            if (done[i]) done_n[i] <= done_n[i] + 1;
            if (rd_en[i]) begin
                rden_n[i]    <= rden_n[i] + 1;
                rden_pos[i]  <= frise[i];
                rden_addr[i] <= rd_addr[i];
                if (frise[i] != 0) pf_n[i] <= pf_n[i] + 1;
                if (prev_rden[i]) rden_long[i] <= rden_long[i] + 1;
            end
            if (spi_cs[i]) begin
                hi_run[i] <= hi_run[i] + 1;
                frise[i]  <= 0;
                bitn[i]   <= 0;
            end else begin
                if (hi_run[i] != 0) last_gap[i] <= hi_run[i];
                hi_run[i] <= 0;
                cs_low[i] <= cs_low[i] + 1;
                if (spi_clk[i]) hi_cyc[i] <= hi_cyc[i] + 1;
                if (spi_clk[i] && !prev_clk[i]) begin
                    rises[i] <= rises[i] + 1;
                    frise[i] <= frise[i] + 1;
                    if (frise[i] != 0 && (cyc - last_rise[i]) != 2 * cd(i))
                        spacing_err[i] <= spacing_err[i] + 1;
                    last_rise[i] <= cyc;
                    cur[i] <= {cur[i][30:0], spi_mosi[i]};
                    if (bitn[i] == 31) begin
                        cap[i][cap_n[i] % 256] <= {cur[i][30:0], spi_mosi[i]};
                        cap_n[i] <= cap_n[i] + 1;
                        bitn[i]  <= 0;
                    end else begin
                        bitn[i] <= bitn[i] + 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
    endtask

    task automatic wait_done(int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done[i]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rise(int i, int tgt, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (frise[i] >= tgt) begin ok = 1'b1; break; end
        end
    endtask

    task automatic fill_random(int i);
        for (int k = 0; k < 4; k++) mem[i][k] = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        tick(3);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({spi_cs[i], spi_clk[i], spi_mosi[i], busy[i], done[i], rd_en[i]} !== 6'b100000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: cs/clk/mosi/busy/done/rd_en got %b expected 100000", i,
                         {spi_cs[i], spi_clk[i], spi_mosi[i], busy[i], done[i], rd_en[i]});
            end
            checks++;
            if (rd_addr[i] !== 11'd0) begin
                errors++;
                $display("FAIL reset_rd_addr dut%0d: got %0d expected 0", i, rd_addr[i]);
            end
        end
        // first start is taken on the first edge after release
        mem[0][0] = 32'hA5A5_0F0F; mem[0][1] = 32'h0; mem[0][2] = 32'h1; mem[0][3] = 32'h2;
        @(negedge clk); resetn = 1'b1; start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || spi_cs[0] !== 1'b0) begin
            errors++;
            $display("FAIL first_start: busy=%b cs=%b expected busy=1 cs=0", busy[0], spi_cs[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d0;
        wait_rise(0, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reset_mid_wait: timed out before bit 40"); end
        d0 = done_n[0];
        @(posedge clk); #2 resetn = 1'b0;
        #1;
        checks++;
        if (spi_cs[0] !== 1'b1 || spi_clk[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: cs=%b clk=%b busy=%b done=%b expected 1 0 0 0",
                     spi_cs[0], spi_clk[0], busy[0], done[0]);
        end
        tick(2);
        @(negedge clk); resetn = 1'b1;
        tick(10);
        checks++;
        if (done_n[0] != d0) begin
            errors++;
            $display("FAIL reset_mid_no_done: done pulses got %0d expected 0", done_n[0] - d0);
        end
    endtask

    task automatic test_frame(int iters, bit fixed);
        bit ok;
        int s_cs, s_r, s_d, s_c;
        for (int it = 0; it < iters; it++) begin
            if (fixed) begin
                mem[0][0] = 32'h8000_0001; mem[0][1] = 32'h1234_5678;
                mem[0][2] = 32'hFFFF_0000; mem[0][3] = 32'h0000_0000;
            end else begin
                fill_random(0);
            end
            s_cs = cs_low[0]; s_r = rises[0]; s_d = done_n[0]; s_c = cap_n[0];
            pulse_start(0);
            wait_done(0, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL frame_done_timeout iter %0d", it); end
            tick(4);
            checks++;
            if (cs_low[0] - s_cs != CD0 * (2 + 64 * W0)) begin
                errors++;
                $display("FAIL frame_cs_low: got %0d expected %0d", cs_low[0] - s_cs, CD0 * (2 + 64 * W0));
            end
            checks++;
            if (rises[0] - s_r != 32 * W0) begin
                errors++;
                $display("FAIL frame_rises: got %0d expected %0d", rises[0] - s_r, 32 * W0);
            end
            checks++;
            if (done_n[0] - s_d != 1) begin
                errors++;
                $display("FAIL frame_done_count: got %0d expected 1", done_n[0] - s_d);
            end
            for (int k = 0; k < W0; k++) begin
                checks++;
                if (cap[0][(s_c + k) % 256] !== mem[0][k]) begin
                    errors++;
                    $display("FAIL frame_word%0d: got %h expected %h", k, cap[0][(s_c + k) % 256], mem[0][k]);
                end
            end
        end
    endtask

    task automatic test_timing();
        bit ok;
        int s_cs, s_r, s_h, s_sp, s_rd, s_pf, s_c;
        fill_random(1);
        s_cs = cs_low[1]; s_r = rises[1]; s_h = hi_cyc[1]; s_sp = spacing_err[1];
        s_rd = rden_n[1]; s_pf = pf_n[1]; s_c = cap_n[1];
        pulse_start(1);
        wait_done(1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timing_done_timeout"); end
        tick(4);
        checks++;
        if (cs_low[1] - s_cs != 130) begin
            errors++; $display("FAIL timing_cs_low: got %0d expected 130", cs_low[1] - s_cs);
        end
        checks++;
        if (rises[1] - s_r != 64 || hi_cyc[1] - s_h != 64 || spacing_err[1] != s_sp) begin
            errors++;
            $display("FAIL timing_toggle: rises=%0d high_cycles=%0d spacing_errs=%0d expected 64 64 0",
                     rises[1] - s_r, hi_cyc[1] - s_h, spacing_err[1] - s_sp);
        end
        // one read for word 0 plus exactly one prefetch
        checks++;
        if (rden_n[1] - s_rd != 2 || pf_n[1] - s_pf != 1) begin
            errors++;
            $display("FAIL timing_rd_en_count: total=%0d prefetch=%0d expected 2 1", rden_n[1] - s_rd, pf_n[1] - s_pf);
        end
        checks++;
        if (rden_pos[1] != 15 || rden_addr[1] !== 11'd1) begin
            errors++;
            $display("FAIL timing_prefetch_pos: bits_done=%0d addr=%0d expected 15 1", rden_pos[1], rden_addr[1]);
        end
        for (int k = 0; k < W1; k++) begin
            checks++;
            if (cap[1][(s_c + k) % 256] !== mem[1][k]) begin
                errors++;
                $display("FAIL timing_word%0d: got %h expected %h", k, cap[1][(s_c + k) % 256], mem[1][k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int s_d, s_c;
        fill_random(0);
        s_d = done_n[0];
        pulse_start(0);
        tick(30);
        pulse_start(0);                    // busy: must be dropped
        wait_done(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_done_timeout_1"); end
        start[0] = 1'b1;                   // high during the done cycle
        @(posedge clk); #1 start[0] = 1'b0;
        tick(4 * CD0);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || spi_cs[0] !== 1'b1 || done_n[0] - s_d != 1) begin
            errors++;
            $display("FAIL b2b_ignored_starts: busy=%b cs=%b dones=%0d expected 0 1 1",
                     busy[0], spi_cs[0], done_n[0] - s_d);
        end
        pulse_start(0);
        wait_done(0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_done_timeout_2"); end
        fill_random(0);
        @(posedge clk); #1 start[0] = 1'b1; // cycle after done
        @(posedge clk); #1 start[0] = 1'b0;
        s_c = cap_n[0];
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++; $display("FAIL b2b_start_after_done: busy got %b expected 1", busy[0]);
        end
        wait_done(0, ok);
        tick(4);
        checks++;
        if (!ok || last_gap[0] != 1) begin
            errors++; $display("FAIL b2b_cs_gap: got %0d cycles expected 1 (done seen %0d)", last_gap[0], ok);
        end
        for (int k = 0; k < W0; k++) begin
            checks++;
            if (cap[0][(s_c + k) % 256] !== mem[0][k]) begin
                errors++;
                $display("FAIL b2b_word%0d: got %h expected %h", k, cap[0][(s_c + k) % 256], mem[0][k]);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int s_d, tgt;
        for (int it = 0; it < 3; it++) begin
            fill_random(0);
            // first abort lands in bit 5 of word 2, the rest at random bits
            tgt = (it == 0) ? 64 + 27 : $urandom_range(1, 127);
            s_d = done_n[0];
            pulse_start(0);
            wait_rise(0, tgt, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL abort_wait iter %0d", it); end
            abort[0] = 1'b1;
            @(posedge clk); #1 abort[0] = 1'b0;
            @(negedge clk);
            checks++;
            if ({spi_cs[0], spi_clk[0], spi_mosi[0], busy[0]} !== 4'b1000) begin
                errors++;
                $display("FAIL abort_outputs at bit %0d: cs/clk/mosi/busy got %b expected 1000",
                         tgt, {spi_cs[0], spi_clk[0], spi_mosi[0], busy[0]});
            end
            tick(3 * CD0 * 64);
            checks++;
            if (done_n[0] != s_d || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done: dones=%0d busy=%b expected 0 0", done_n[0] - s_d, busy[0]);
            end
        end
        // abort beats start in IDLE
        @(posedge clk); #1 start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0; abort[0] = 1'b0;
        tick(3);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || spi_cs[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_start_idle: busy=%b cs=%b expected 0 1", busy[0], spi_cs[0]);
        end
        test_frame(1, 1'b0);   // next frame starts again from word 0
    endtask

    task automatic test_checker();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mosi_err[i] != 0 || csclk_err[i] != 0 || spacing_err[i] != 0 || rden_long[i] != 0) begin
                errors++;
                $display("FAIL protocol dut%0d: mosi_moves_high=%0d clk_with_cs_high=%0d bit_spacing=%0d long_rd_en=%0d expected all 0",
                         i, mosi_err[i], csclk_err[i], spacing_err[i], rden_long[i]);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) mem[i][k] = 32'h0;
        test_reset();
        test_reset_mid();
        test_frame(1, 1'b1);
        test_frame(3, 1'b0);
        test_timing();
        test_back_to_back();
        test_abort();
        test_checker();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
